// File: rtl/song_note_reader.sv
// Reference-note producer: walks one song in the note BRAM and drives each note for its duration.
// A word is {end, duration units, note}. Playback ends on an end marker or after the last slot of the song.
module song_note_reader #(
    parameter int OFFSET_BITS = 8,
    parameter int ROM_LATENCY = 2,
    parameter int TICK_CYCLES = 12_500_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic                   stop,
    input  logic [1:0]             song_id,
    output logic [OFFSET_BITS+1:0] rom_addr,
    input  logic [11:0]            rom_data,
    output logic [6:0]             note,
    output logic                   note_strobe,
    output logic                   playing,
    output logic                   song_done
);

    localparam int AW = OFFSET_BITS + 2;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int WW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ROM_LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } state_t;

    state_t            state_reg,    state_next;
    logic [AW-1:0]     rom_addr_reg, rom_addr_next;
    logic [6:0]        note_reg,     note_next;
    logic              strobe_reg,   strobe_next;
    logic              done_reg,     done_next;
    logic              playing_reg,  playing_next;
    logic [WW-1:0]     wait_cnt_reg, wait_cnt_next;
    logic [TW-1:0]     tick_cnt_reg, tick_cnt_next;
    logic [3:0]        units_reg,    units_next;

    logic              word_end;
    logic [3:0]        word_dur;
    logic [6:0]        word_note;
    logic              offset_last;
    logic [OFFSET_BITS-1:0] offset_inc;

    assign word_end    = rom_data[11];
    assign word_dur    = rom_data[10:7];
    assign word_note   = rom_data[6:0];
    assign offset_last = &rom_addr_reg[OFFSET_BITS-1:0];
    assign offset_inc  = rom_addr_reg[OFFSET_BITS-1:0] + OFFSET_BITS'(1);

    always_comb begin
        state_next    = state_reg;
        rom_addr_next = rom_addr_reg;
        note_next     = note_reg;
        strobe_next   = 1'b0;
        done_next     = 1'b0;
        playing_next  = playing_reg;
        wait_cnt_next = wait_cnt_reg;
        tick_cnt_next = tick_cnt_reg;
        units_next    = units_reg;

        if (stop) begin
            // Abort: rom_addr is left where it was, only the note and status drop.
            state_next    = IDLE;
            note_next     = 7'd0;
            playing_next  = 1'b0;
            wait_cnt_next = '0;
            tick_cnt_next = '0;
            units_next    = 4'd0;
        end else if (start) begin
            // Any pending fetch is abandoned; the old note stays up until the new one lands.
            state_next    = FETCH;
            rom_addr_next = {song_id, {OFFSET_BITS{1'b0}}};
            wait_cnt_next = '0;
            tick_cnt_next = '0;
            playing_next  = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                FETCH: begin
                    if (wait_cnt_reg == WAIT_LAST) begin
                        if (word_end) begin
                            state_next   = IDLE;
                            note_next    = 7'd0;
                            done_next    = 1'b1;
                            playing_next = 1'b0;
                        end else begin
                            state_next    = PLAY;
                            note_next     = word_note;
                            strobe_next   = 1'b1;
                            units_next    = (word_dur == 4'd0) ? 4'd1 : word_dur;
                            tick_cnt_next = '0;
                        end
                    end else begin
                        wait_cnt_next = wait_cnt_reg + WW'(1);
                    end
                end
                PLAY: begin
                    if (tick_cnt_reg == TICK_LAST) begin
                        tick_cnt_next = '0;
                        if (units_reg == 4'd1) begin
                            units_next = 4'd0;
                            if (offset_last) begin
                                // Song filled every slot without an end marker; never wrap.
                                state_next   = IDLE;
                                note_next    = 7'd0;
                                done_next    = 1'b1;
                                playing_next = 1'b0;
                            end else begin
                                state_next    = FETCH;
                                rom_addr_next = {rom_addr_reg[AW-1:OFFSET_BITS], offset_inc};
                                wait_cnt_next = '0;
                            end
                        end else begin
                            units_next = units_reg - 4'd1;
                        end
                    end else begin
                        tick_cnt_next = tick_cnt_reg + TW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg    <= IDLE;
            rom_addr_reg <= '0;
            note_reg     <= 7'd0;
            strobe_reg   <= 1'b0;
            done_reg     <= 1'b0;
            playing_reg  <= 1'b0;
            wait_cnt_reg <= '0;
            tick_cnt_reg <= '0;
            units_reg    <= 4'd0;
        end else begin
            state_reg    <= state_next;
            rom_addr_reg <= rom_addr_next;
            note_reg     <= note_next;
            strobe_reg   <= strobe_next;
            done_reg     <= done_next;
            playing_reg  <= playing_next;
            wait_cnt_reg <= wait_cnt_next;
            tick_cnt_reg <= tick_cnt_next;
            units_reg    <= units_next;
        end
    end

    assign rom_addr    = rom_addr_reg;
    assign note        = note_reg;
    assign note_strobe = strobe_reg;
    assign song_done   = done_reg;
    assign playing     = playing_reg;

endmodule

// File: tb/tb_song_note_reader.sv
// Bench for song_note_reader: latency-exact BRAM model plus a timestamped scoreboard of
// expected strobes and song_done pulses, built from the song contents when start is driven.
module tb_song_note_reader;

    localparam int L = 2;
    localparam int T = 4;
    localparam int OB = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  song_id = 2'd0;
    logic [9:0]  rom_addr;
    logic [11:0] rom_data;
    logic [6:0]  note;
    logic        note_strobe;
    logic        playing;
    logic        song_done;

    song_note_reader #(
        .OFFSET_BITS(OB),
        .ROM_LATENCY(L),
        .TICK_CYCLES(T)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start(start),
        .stop(stop),
        .song_id(song_id),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .note(note),
        .note_strobe(note_strobe),
        .playing(playing),
        .song_done(song_done)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: data for an address appears exactly L edges after the address changes.
    logic [11:0] mem [0:1023];
    logic [11:0] pipe [0:L-1];
    always @(posedge clk_in) begin
        pipe[0] <= mem[rom_addr];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rom_data = pipe[L-1];

    int unsigned edge_cnt = 0;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    typedef struct {
        bit          is_done;
        logic [6:0]  note_v;
        int unsigned at_edge;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Expected event stream for a song whose start is sampled at edge s.
    task automatic push_song(input logic [1:0] id, input int unsigned s);
        int unsigned t;
        int unsigned cap;
        int unsigned d;
        logic [11:0] w;
        logic [9:0]  a;
        exp_t e;
        t = s;
        for (int off = 0; off < 256; off++) begin
            cap = t + L + 1;
            a = {id, off[7:0]};
            w = mem[a];
            if (w[11]) begin
                e.is_done = 1'b1; e.note_v = 7'd0; e.at_edge = cap;
                sb.push_back(e);
                return;
            end
            d = (w[10:7] == 4'd0) ? 1 : int'(w[10:7]);
            e.is_done = 1'b0; e.note_v = w[6:0]; e.at_edge = cap;
            sb.push_back(e);
            t = cap + d * T;
            if (off == 255) begin
                e.is_done = 1'b1; e.note_v = 7'd0; e.at_edge = t;
                sb.push_back(e);
                return;
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in && (note_strobe || song_done)) begin
            check("strobe_and_done", {31'd0, note_strobe & song_done}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_event", {30'd0, note_strobe, song_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("edge %0d: %s note=%0d playing=%0d", edge_cnt,
                         song_done ? "done  " : "strobe", note, playing);
                check("event_kind", {31'd0, song_done}, {31'd0, e.is_done});
                check("event_edge", edge_cnt, e.at_edge);
                check("event_note", {25'd0, note}, e.is_done ? 32'd0 : {25'd0, e.note_v});
                check("event_playing", {31'd0, playing}, e.is_done ? 32'd0 : 32'd1);
            end
        end
    end

    task automatic do_start(input logic [1:0] id, output int unsigned s);
        @(negedge clk_in); #1;
        song_id = id;
        start = 1'b1;
        s = edge_cnt + 1;
        sb.delete();
        push_song(id, s);
        @(negedge clk_in); #1;
        start = 1'b0;
    endtask

    task automatic wait_to_edge(input int unsigned n);
        while (edge_cnt < n) @(negedge clk_in);
    endtask

    task automatic wait_sb_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (10) @(negedge clk_in);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_note"}, {25'd0, note}, 32'd0);
        check({tag, "_rom_addr"}, {22'd0, rom_addr}, 32'd0);
        check({tag, "_strobe"}, {31'd0, note_strobe}, 32'd0);
        check({tag, "_done"}, {31'd0, song_done}, 32'd0);
        check({tag, "_playing"}, {31'd0, playing}, 32'd0);
    endtask

    int unsigned s;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {1'b1, 4'd0, 7'd0};
        mem[10'h100] = {1'b0, 4'd2, 7'd60};
        mem[10'h101] = {1'b0, 4'd1, 7'd62};
        mem[10'h000] = {1'b0, 4'd0, 7'd55};
        mem[10'h001] = {1'b0, 4'd3, 7'd70};
        mem[10'h200] = {1'b0, 4'd1, 7'd40};
        mem[10'h201] = {1'b0, 4'd2, 7'd0};
        for (int i = 0; i < 256; i++) mem[10'h300 + i] = {1'b0, 4'd1, 7'((i % 100) + 1)};

        // Power-on reset
        repeat (3) @(negedge clk_in);
        check_idle_outputs("reset");
        #1 rst_in = 1'b0;

        // Two-note song with end marker, plus address timing
        do_start(2'd1, s);
        check("s1_addr_after_start", {22'd0, rom_addr}, 32'h100);
        check("s1_playing_after_start", {31'd0, playing}, 32'd1);
        check("s1_note_during_fetch", {25'd0, note}, 32'd0);
        wait_to_edge(s + 10);
        check("s1_addr_last_play", {22'd0, rom_addr}, 32'h100);
        wait_to_edge(s + 11);
        check("s1_addr_next_word", {22'd0, rom_addr}, 32'h101);
        check("s1_note_held_in_fetch", {25'd0, note}, 32'd60);
        wait_sb_empty(200);
        check("s1_end_playing", {31'd0, playing}, 32'd0);
        check("s1_end_note", {25'd0, note}, 32'd0);

        // Zero duration counts as one unit
        do_start(2'd0, s);
        wait_sb_empty(200);

        // Stop during PLAY: no song_done afterwards
        do_start(2'd1, s);
        wait_to_edge(s + 6);
        check("stop_note_before", {25'd0, note}, 32'd60);
        #1 stop = 1'b1;
        sb.delete();
        @(negedge clk_in);
        check("stop_note", {25'd0, note}, 32'd0);
        check("stop_playing", {31'd0, playing}, 32'd0);
        check("stop_addr_held", {22'd0, rom_addr}, 32'h100);
        #1 stop = 1'b0;
        repeat (30) @(negedge clk_in);

        // Restart on another song mid-PLAY
        do_start(2'd1, s);
        wait_to_edge(s + 5);
        do_start(2'd2, s);
        check("restart_addr", {22'd0, rom_addr}, 32'h200);
        check("restart_note_held", {25'd0, note}, 32'd60);
        check("restart_playing", {31'd0, playing}, 32'd1);
        wait_to_edge(s + 2);
        check("restart_note_held_late", {25'd0, note}, 32'd60);
        wait_sb_empty(200);

        // Full 256-word song without an end marker
        do_start(2'd3, s);
        wait_sb_empty(4000);
        check("full_song_addr_no_wrap", {22'd0, rom_addr}, 32'h3FF);
        check("full_song_playing", {31'd0, playing}, 32'd0);

        // Reset together with start during FETCH
        do_start(2'd1, s);
        rst_in = 1'b1;
        start = 1'b1;
        song_id = 2'd2;
        sb.delete();
        @(negedge clk_in);
        check_idle_outputs("midreset");
        #1;
        rst_in = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk_in);
        check("midreset_note_after", {25'd0, note}, 32'd0);
        check("midreset_playing_after", {31'd0, playing}, 32'd0);

        // Start and stop together: stop wins
        #1;
        song_id = 2'd3;
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk_in);
        check("start_stop_playing", {31'd0, playing}, 32'd0);
        check("start_stop_addr", {22'd0, rom_addr}, 32'd0);
        #1;
        start = 1'b0;
        stop = 1'b0;
        repeat (20) @(negedge clk_in);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
